// File: rtl/food_placer_pkg.sv
// -----------------------------------------------------------------------------
// food_placer_pkg
//   Shared constants for the snake-game food placer. These are the playfield
//   limits, the wall outline, the reset food position and LFSR settings. The
//   package also holds the placement FSM state encoding and the LFSR step
//   function.
// -----------------------------------------------------------------------------
package food_placer_pkg;

  localparam int unsigned FP_COORD_W   = 8;
  localparam int unsigned FP_N_FOOD    = 2;

  // Legal food cells (inclusive)
  localparam logic [7:0]  FP_X_MIN     = 8'h11;
  localparam logic [7:0]  FP_X_MAX     = 8'h89;
  localparam logic [7:0]  FP_Y_MIN     = 8'h0B;
  localparam logic [7:0]  FP_Y_MAX     = 8'h6D;

  // Wall is drawn strictly outside these limits
  localparam logic [7:0]  FP_WALL_XL   = 8'h10;
  localparam logic [7:0]  FP_WALL_XH   = 8'h90;
  localparam logic [7:0]  FP_WALL_YL   = 8'h0A;
  localparam logic [7:0]  FP_WALL_YH   = 8'h6E;

  localparam logic [7:0]  FP_INIT_X    = 8'h50;
  localparam logic [7:0]  FP_INIT_Y    = 8'h47;

  localparam logic [15:0] FP_LFSR_SEED = 16'hACE1;
  localparam logic [15:0] FP_LFSR_TAPS = 16'hB400;
  localparam int unsigned FP_MAX_TRIES = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PROPOSE = 2'd1,
    ST_CHECK   = 2'd2,
    ST_COMMIT  = 2'd3
  } fsm_state_e;

  // One step of the right-shifting Galois LFSR
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? FP_LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/food_placer_lfsr16.sv
// -----------------------------------------------------------------------------
// food_placer_lfsr16
//   Free-running 16-bit Galois LFSR that serves as the random cell source.
//   Ports:
//     clk     in   clock
//     rst     in   asynchronous active-low reset (loads SEED)
//     en      in   advance one step per cycle when high
//     lfsr_o  out  current LFSR state
// -----------------------------------------------------------------------------
module food_placer_lfsr16
  import food_placer_pkg::*;
#(
  parameter logic [15:0] SEED = FP_LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = en ? lfsr_step(lfsr_q) : lfsr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/food_placer.sv
// -----------------------------------------------------------------------------
// food_placer
//   Keeps N_FOOD food slots inside the playfield. When a food is eaten, the
//   placer puts new food at an LFSR-random cell. Cells that hold the snake
//   (found through the chk_* handshake) or other food are rejected. The block
//   also registers the food and wall pixel flags for the VGA drawing path.
//   Ports:
//     clk, rst            clock; asynchronous active-low reset
//     c_pixel, r_pixel    current pixel column/row
//     gen_food[N_FOOD]    per-slot "eaten, replace" pulse
//     game_over           freeze: abort the search and blank the food
//     chk_req/chk_X/chk_Y occupancy query (held stable until acknowledged)
//     chk_ack/chk_hit     query answer; chk_hit is valid with chk_ack
//     food_X/food_Y       packed slot coordinates, slot i at [i*COORD_W +: COORD_W]
//     food_valid          slot holds a placed food
//     food_prnt           registered: current pixel is a valid food
//     bound_prnt          registered: current pixel is wall
//     busy                placement in progress
//     gen_fail            1-cycle pulse: slot left empty after MAX_TRIES rejections
// -----------------------------------------------------------------------------
module food_placer
  import food_placer_pkg::*;
#(
  parameter int unsigned        COORD_W   = FP_COORD_W,
  parameter int unsigned        N_FOOD    = FP_N_FOOD,
  parameter logic [COORD_W-1:0] X_MIN     = COORD_W'(FP_X_MIN),
  parameter logic [COORD_W-1:0] X_MAX     = COORD_W'(FP_X_MAX),
  parameter logic [COORD_W-1:0] Y_MIN     = COORD_W'(FP_Y_MIN),
  parameter logic [COORD_W-1:0] Y_MAX     = COORD_W'(FP_Y_MAX),
  parameter logic [COORD_W-1:0] WALL_XL   = COORD_W'(FP_WALL_XL),
  parameter logic [COORD_W-1:0] WALL_XH   = COORD_W'(FP_WALL_XH),
  parameter logic [COORD_W-1:0] WALL_YL   = COORD_W'(FP_WALL_YL),
  parameter logic [COORD_W-1:0] WALL_YH   = COORD_W'(FP_WALL_YH),
  parameter logic [COORD_W-1:0] INIT_X    = COORD_W'(FP_INIT_X),
  parameter logic [COORD_W-1:0] INIT_Y    = COORD_W'(FP_INIT_Y),
  parameter logic [15:0]        LFSR_SEED = FP_LFSR_SEED,
  parameter int unsigned        MAX_TRIES = FP_MAX_TRIES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [COORD_W-1:0]          c_pixel,
  input  logic [COORD_W-1:0]          r_pixel,
  input  logic [N_FOOD-1:0]           gen_food,
  input  logic                        game_over,
  output logic                        chk_req,
  output logic [COORD_W-1:0]          chk_X,
  output logic [COORD_W-1:0]          chk_Y,
  input  logic                        chk_ack,
  input  logic                        chk_hit,
  output logic [N_FOOD*COORD_W-1:0]   food_X,
  output logic [N_FOOD*COORD_W-1:0]   food_Y,
  output logic [N_FOOD-1:0]           food_valid,
  output logic                        food_prnt,
  output logic                        bound_prnt,
  output logic                        busy,
  output logic                        gen_fail
);

  localparam int unsigned      IDX_W     = (N_FOOD > 1) ? $clog2(N_FOOD) : 1;
  localparam int unsigned      TRY_W     = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);

  fsm_state_e          state_q;
  logic [IDX_W-1:0]    cur_idx_q;
  logic [TRY_W-1:0]    tries_q;
  logic [COORD_W-1:0]  cand_x_q, cand_y_q;
  logic                gen_fail_q;
  logic [COORD_W-1:0]  slot_x_q [N_FOOD];
  logic [COORD_W-1:0]  slot_y_q [N_FOOD];
  logic [N_FOOD-1:0]   valid_q, valid_d;
  logic [N_FOOD-1:0]   pending_q, pending_d;
  logic                food_prnt_q, bound_prnt_q;

  logic [15:0]         lfsr_val;
  logic [COORD_W-1:0]  cand_x, cand_y;
  logic                cand_in_field;
  logic [N_FOOD-1:0]   coll_vec, pix_vec;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_go, abort, commit_go;
  logic [N_FOOD-1:0]   pick_onehot, cur_onehot;
  logic [TRY_W-1:0]    tries_inc;
  logic                tries_out;

  food_placer_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .en     (1'b1),
    .lfsr_o (lfsr_val)
  );

  assign cand_x = COORD_W'(lfsr_val[7:0]);
  assign cand_y = COORD_W'(lfsr_val[15:8]);
  assign cand_in_field = (cand_x >= X_MIN) && (cand_x <= X_MAX) &&
                         (cand_y >= Y_MIN) && (cand_y <= Y_MAX);

  // Per-slot compares: candidate collision (the slot being placed is excluded),
  // pixel match, and output packing.
  generate
    for (genvar gi = 0; gi < N_FOOD; gi++) begin : g_slot
      assign coll_vec[gi] = valid_q[gi] && (cur_idx_q != IDX_W'(gi)) &&
                            (slot_x_q[gi] == cand_x) && (slot_y_q[gi] == cand_y);
      assign pix_vec[gi]  = valid_q[gi] && (c_pixel == slot_x_q[gi]) &&
                            (r_pixel == slot_y_q[gi]);
      assign food_X[gi*COORD_W +: COORD_W] = slot_x_q[gi];
      assign food_Y[gi*COORD_W +: COORD_W] = slot_y_q[gi];
    end
  endgenerate

  // Lowest pending slot wins
  always_comb begin
    pick_idx = '0;
    for (int i = N_FOOD - 1; i >= 0; i--) begin
      if (pending_q[i]) pick_idx = IDX_W'(i);
    end
  end

  assign pick_go     = (state_q == ST_IDLE) && !game_over && (pending_q != '0);
  assign abort       = (state_q != ST_IDLE) && game_over;
  assign commit_go   = (state_q == ST_COMMIT) && !game_over;
  assign pick_onehot = N_FOOD'(1) << pick_idx;
  assign cur_onehot  = N_FOOD'(1) << cur_idx_q;

  // Saturating try counter; a placement ends once it reaches the limit
  assign tries_inc = (tries_q == TRY_LIMIT) ? tries_q : tries_q + TRY_W'(1);
  assign tries_out = (tries_inc == TRY_LIMIT);

  // gen_food is applied last, so an eat request beats a same-cycle pick
  // (pending) and a same-cycle commit (valid).
  always_comb begin
    pending_d = pending_q;
    if (pick_go) pending_d = pending_d & ~pick_onehot;
    if (abort)   pending_d = pending_d | cur_onehot;
    pending_d = pending_d | gen_food;

    valid_d = valid_q;
    if (commit_go) valid_d = valid_d | cur_onehot;
    valid_d = valid_d & ~gen_food;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= N_FOOD'(1);
      pending_q <= ~N_FOOD'(1);
    end else begin
      valid_q   <= valid_d;
      pending_q <= pending_d;
    end
  end

  // Placement FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cur_idx_q  <= '0;
      tries_q    <= '0;
      cand_x_q   <= '0;
      cand_y_q   <= '0;
      gen_fail_q <= 1'b0;
      for (int i = 0; i < N_FOOD; i++) begin
        slot_x_q[i] <= (i == 0) ? INIT_X : '0;
        slot_y_q[i] <= (i == 0) ? INIT_Y : '0;
      end
    end else begin
      gen_fail_q <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (pick_go) begin
              cur_idx_q <= pick_idx;
              tries_q   <= '0;
              state_q   <= ST_PROPOSE;
            end
          end
          ST_PROPOSE: begin
            cand_x_q <= cand_x;
            cand_y_q <= cand_y;
            // Out-of-field candidates are skipped for free; a clash with
            // another food costs a try.
            if (cand_in_field) begin
              if (coll_vec != '0) begin
                tries_q <= tries_inc;
                if (tries_out) begin
                  gen_fail_q <= 1'b1;
                  state_q    <= ST_IDLE;
                end
              end else begin
                state_q <= ST_CHECK;
              end
            end
          end
          ST_CHECK: begin
            if (chk_ack) begin
              if (chk_hit) begin
                tries_q <= tries_inc;
                if (tries_out) begin
                  gen_fail_q <= 1'b1;
                  state_q    <= ST_IDLE;
                end else begin
                  state_q <= ST_PROPOSE;
                end
              end else begin
                state_q <= ST_COMMIT;
              end
            end
          end
          ST_COMMIT: begin
            slot_x_q[cur_idx_q] <= cand_x_q;
            slot_y_q[cur_idx_q] <= cand_y_q;
            state_q             <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Pixel flags, one cycle behind c_pixel/r_pixel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      food_prnt_q  <= 1'b0;
      bound_prnt_q <= 1'b0;
    end else begin
      food_prnt_q  <= !game_over && (pix_vec != '0);
      bound_prnt_q <= (c_pixel < WALL_XL) || (c_pixel > WALL_XH) ||
                      (r_pixel < WALL_YL) || (r_pixel > WALL_YH);
    end
  end

  assign chk_req    = (state_q == ST_CHECK);
  assign chk_X      = cand_x_q;
  assign chk_Y      = cand_y_q;
  assign food_valid = valid_q;
  assign food_prnt  = food_prnt_q;
  assign bound_prnt = bound_prnt_q;
  assign busy       = (state_q != ST_IDLE);
  assign gen_fail   = gen_fail_q;

endmodule

// File: tb/tb_food_placer.sv
// -----------------------------------------------------------------------------
// tb_food_placer
//   Self-checking bench for food_placer: directed scenarios followed by a
//   randomized placement/pixel phase, compared against a slot-level model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_food_placer;

  localparam int NF = 2;
  localparam logic [7:0] XMIN = 8'h11, XMAX = 8'h89, YMIN = 8'h0B, YMAX = 8'h6D;
  localparam logic [7:0] WXL = 8'h10, WXH = 8'h90, WYL = 8'h0A, WYH = 8'h6E;
  localparam int MAXT = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [7:0]      c_pixel = 8'h00, r_pixel = 8'h00;
  logic [NF-1:0]   gen_food = '0;
  logic            game_over = 1'b0;
  logic            chk_req, chk_ack = 1'b0, chk_hit = 1'b0;
  logic [7:0]      chk_X, chk_Y;
  logic [NF*8-1:0] food_X, food_Y;
  logic [NF-1:0]   food_valid;
  logic            food_prnt, bound_prnt, busy, gen_fail;

  always #5 clk = ~clk;

  food_placer dut (
    .clk(clk), .rst(rst), .c_pixel(c_pixel), .r_pixel(r_pixel),
    .gen_food(gen_food), .game_over(game_over),
    .chk_req(chk_req), .chk_X(chk_X), .chk_Y(chk_Y),
    .chk_ack(chk_ack), .chk_hit(chk_hit),
    .food_X(food_X), .food_Y(food_Y), .food_valid(food_valid),
    .food_prnt(food_prnt), .bound_prnt(bound_prnt),
    .busy(busy), .gen_fail(gen_fail)
  );

  int checks = 0, failures = 0;
  int hs_count = 0, fail_pulses = 0;

  // Model: what each slot should hold
  bit         m_valid [NF];
  logic [7:0] m_x [NF];
  logic [7:0] m_y [NF];

  always @(posedge clk) begin
    if (rst && chk_req && chk_ack) hs_count++;
    if (rst && gen_fail) fail_pulses++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NF-1:0] model_vec();
    logic [NF-1:0] v;
    for (int i = 0; i < NF; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic bit in_field(input logic [7:0] x, input logic [7:0] y);
    return (x >= XMIN) && (x <= XMAX) && (y >= YMIN) && (y <= YMAX);
  endfunction

  task automatic pixel_check(input logic [7:0] c, input logic [7:0] r);
    bit ef, eb;
    c_pixel = c; r_pixel = r;
    @(negedge clk);
    ef = 1'b0;
    for (int i = 0; i < NF; i++)
      if (m_valid[i] && m_x[i] == c && m_y[i] == r) ef = 1'b1;
    ef = ef && !game_over;
    eb = (c < WXL) || (c > WXH) || (r < WYL) || (r > WYH);
    check_val("food_prnt", food_prnt, ef);
    check_val("bound_prnt", bound_prnt, eb);
    $display("PIX c=%02h r=%02h food=%0d bound=%0d", c, r, food_prnt, bound_prnt);
  endtask

  // Wait (bounded) for a query, optionally stall, then answer it
  task automatic serve_check(input bit hit, input int delay, input int budget,
                             output logic [7:0] cx, output logic [7:0] cy, output bit ok);
    int n = 0;
    bit stable = 1'b1;
    ok = 1'b0; cx = '0; cy = '0;
    while (!chk_req && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!chk_req) begin
      check_val("chk_req_timeout", chk_req, 1);
      return;
    end
    cx = chk_X; cy = chk_Y;
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      if (!chk_req || chk_X !== cx || chk_Y !== cy) stable = 1'b0;
    end
    if (delay > 0) check_val("chk_stable", stable, 1);
    chk_hit = hit; chk_ack = 1'b1;
    @(negedge clk);
    chk_ack = 1'b0; chk_hit = 1'b0;
    ok = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("busy_idle", busy, 0);
  endtask

  task automatic request(input int idx);
    gen_food = NF'(1) << idx;
    @(negedge clk);
    gen_food = '0;
    m_valid[idx] = 1'b0;
    check_val("valid_clear", food_valid, model_vec());
  endtask

  // Run one placement of slot idx against the responder settings
  task automatic place_slot(input int idx, input bit do_req, input int hit_pct,
                            input int dmin, input int dmax, input int budget);
    int hits = 0, hs0, fp0, oth;
    bit done = 1'b0, ok, h;
    logic [7:0] cx = '0, cy = '0;
    oth = (idx == 0) ? 1 : 0;
    if (do_req) request(idx);
    hs0 = hs_count; fp0 = fail_pulses;
    while (!done) begin
      h = ($urandom_range(99) < hit_pct);
      serve_check(h, $urandom_range(dmax, dmin), budget, cx, cy, ok);
      if (!ok) return;
      check_val("cand_in_field", in_field(cx, cy), 1);
      if (m_valid[oth]) check_val("cand_distinct", (cx != m_x[oth]) || (cy != m_y[oth]), 1);
      if (!h) done = 1'b1;
      else begin
        hits++;
        if (hits == MAXT) done = 1'b1;
      end
    end
    if (hits == MAXT) check_val("gen_fail_pulse", gen_fail, 1);
    wait_idle();
    @(negedge clk);
    check_val("gen_fail_low", gen_fail, 0);
    check_val("handshakes", hs_count - hs0, hits + ((hits == MAXT) ? 0 : 1));
    if (hits == MAXT) begin
      check_val("fail_count", fail_pulses - fp0, 1);
      $display("PLACE slot=%0d exhausted after %0d hits", idx, hits);
    end else begin
      m_valid[idx] = 1'b1; m_x[idx] = cx; m_y[idx] = cy;
      check_val("fail_count", fail_pulses - fp0, 0);
      check_val("food_x", food_X[idx*8 +: 8], cx);
      check_val("food_y", food_Y[idx*8 +: 8], cy);
      $display("PLACE slot=%0d at (%02h,%02h) hits=%0d", idx, cx, cy, hits);
    end
    check_val("valid_vec", food_valid, model_vec());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cx, cy;
    bit ok, idle_ok;
    int n;
    // ---------------- reset ----------------
    m_valid[0] = 1'b1; m_x[0] = 8'h50; m_y[0] = 8'h47;
    m_valid[1] = 1'b0; m_x[1] = 8'h00; m_y[1] = 8'h00;
    repeat (3) @(negedge clk);
    check_val("rst_valid", food_valid, 2'b01);
    check_val("rst_food_x", food_X, 16'h0050);
    check_val("rst_food_y", food_Y, 16'h0047);
    check_val("rst_chk_req", chk_req, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_gen_fail", gen_fail, 0);
    check_val("rst_food_prnt", food_prnt, 0);
    check_val("rst_bound_prnt", bound_prnt, 0);
    $display("RESET done");
    rst = 1'b1;

    // ---------------- pixel path + initial slot1 ----------------
    pixel_check(8'h50, 8'h47);
    pixel_check(8'h0F, 8'h47);
    pixel_check(8'h10, 8'h0A);
    place_slot(1, 1'b0, 0, 0, 0, 60);

    // ---------------- replace slot0, same-cycle ack ----------------
    place_slot(0, 1'b1, 0, 0, 0, 200);

    // ---------------- always-hit responder ----------------
    place_slot(1, 1'b1, 100, 0, 0, 200);

    // ---------------- delayed ack (5 cycles) ----------------
    place_slot(1, 1'b1, 0, 5, 5, 200);

    // ---------------- game_over during CHECK ----------------
    c_pixel = m_x[1]; r_pixel = m_y[1];
    request(0);
    n = 0;
    while (!chk_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("go_chk_req_seen", chk_req, 1);
    game_over = 1'b1;
    @(negedge clk);
    check_val("go_chk_req", chk_req, 0);
    check_val("go_busy", busy, 0);
    check_val("go_food_prnt", food_prnt, 0);
    idle_ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (busy || chk_req) idle_ok = 1'b0;
    end
    check_val("go_frozen", idle_ok, 1);
    game_over = 1'b0;
    @(negedge clk);
    check_val("go_food_prnt_back", food_prnt, 1);
    $display("GAME_OVER abort and release done");
    place_slot(0, 1'b0, 0, 0, 2, 200);

    // ---------------- randomized phase ----------------
    for (int t = 0; t < 12; t++) begin
      place_slot($urandom_range(NF - 1), 1'b1, 30, 0, 3, 200);
      for (int p = 0; p < 3; p++) begin
        int s;
        s = $urandom_range(NF - 1);
        if (m_valid[s] && $urandom_range(1)) pixel_check(m_x[s], m_y[s]);
        else pixel_check(8'($urandom), 8'($urandom_range(8'h7F)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
